// File: rtl/bubble_buffer_loader.sv
// Bubble buffer loader: SPI-flash reader (cmd 0x03) that serializes bootloader/page bytes into D0/D1 buffer writes.
// Optional LOADER_PAD_EN: USER loads are framed by zero pad writes (6 before, 138 after the data).
module bubble_buffer_loader #(
    parameter int unsigned SPI_DIV   = 2,
    parameter logic [23:0] BOOT_BASE = 24'h000000,
    parameter logic [23:0] PAGE_BASE = 24'h001000
) (
    input  logic        MCLK,
    input  logic        nRESET,
    input  logic        LOADREQ,
    input  logic [2:0]  ACCTYPE,
    input  logic [11:0] ABSPOS,
    output logic        LOADBUSY,
    output logic        LOADDONE,
    output logic        nCS,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic [14:0] BUFWRADDR,
    output logic        BUFWRCLK,
    output logic        BUFWRDATA
);

`ifdef LOADER_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam int unsigned DIV_W = $clog2(SPI_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPI_DIV - 1);
    localparam logic [14:0] BOOT_FIRST = 15'd4106;
    localparam logic [14:0] USER_FIRST = 15'd14342;
    localparam logic [14:0] PAD_FIRST  = 15'd14336;
    localparam logic [8:0]  BOOT_BYTES = 9'd480;
    localparam logic [8:0]  USER_BYTES = 9'd128;
    localparam logic [7:0]  PRE_LAST   = 8'd5;
    localparam logic [7:0]  POST_LAST  = 8'd137;

    typedef enum logic [2:0] {
        S_IDLE, S_PADPRE, S_CMD, S_RDBYTE, S_WRBITS, S_PADPOST, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
    logic [4:0]        bit_cnt, bit_cnt_nxt;
    logic [31:0]       cmd_sr, cmd_sr_nxt;
    logic [7:0]        rx_sr, rx_sr_nxt;
    logic [8:0]        bytes_left, bytes_left_nxt;
    logic [1:0]        wr_phase, wr_phase_nxt;
    logic [7:0]        wr_cnt, wr_cnt_nxt;
    logic              is_user, is_user_nxt;
    logic              busy, busy_nxt;
    logic              done, done_nxt;
    logic              ncs, ncs_nxt;
    logic              sclk, sclk_nxt;
    logic              mosi, mosi_nxt;
    logic [14:0]       addr, addr_nxt;
    logic              wrclk, wrclk_nxt;
    logic              wrdata, wrdata_nxt;

    logic        req_ok;
    logic [23:0] flash_addr;
    logic        div_end;
    logic        wr_end;
    logic        in_write;

    assign req_ok     = LOADREQ && (ACCTYPE[2:1] == 2'b11);
    assign flash_addr = ACCTYPE[0] ? (PAGE_BASE + 24'({ABSPOS, 7'b0})) : BOOT_BASE;
    assign div_end    = (div_cnt == DIV_LAST);
    assign wr_end     = (wr_phase == 2'd2);
    assign in_write   = (state == S_PADPRE) || (state == S_WRBITS) || (state == S_PADPOST);

    // State and all registered outputs
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            cmd_sr     <= '0;
            rx_sr      <= '0;
            bytes_left <= '0;
            wr_phase   <= '0;
            wr_cnt     <= '0;
            is_user    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ncs        <= 1'b1;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            addr       <= '0;
            wrclk      <= 1'b0;
            wrdata     <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            cmd_sr     <= cmd_sr_nxt;
            rx_sr      <= rx_sr_nxt;
            bytes_left <= bytes_left_nxt;
            wr_phase   <= wr_phase_nxt;
            wr_cnt     <= wr_cnt_nxt;
            is_user    <= is_user_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            ncs        <= ncs_nxt;
            sclk       <= sclk_nxt;
            mosi       <= mosi_nxt;
            addr       <= addr_nxt;
            wrclk      <= wrclk_nxt;
            wrdata     <= wrdata_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt      = state;
        div_cnt_nxt    = div_cnt;
        bit_cnt_nxt    = bit_cnt;
        cmd_sr_nxt     = cmd_sr;
        rx_sr_nxt      = rx_sr;
        bytes_left_nxt = bytes_left;
        wr_phase_nxt   = wr_phase;
        wr_cnt_nxt     = wr_cnt;
        is_user_nxt    = is_user;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        ncs_nxt        = ncs;
        sclk_nxt       = sclk;
        mosi_nxt       = mosi;
        addr_nxt       = addr;
        wrclk_nxt      = wrclk;
        wrdata_nxt     = wrdata;

        // Write strobe phases 0 and 1 are common to data and pad writes
        if (in_write && !wr_end) begin
            wrclk_nxt    = (wr_phase == 2'd0);
            wr_phase_nxt = wr_phase + 2'd1;
        end

        case (state)
            S_IDLE: begin
                if (req_ok) begin
                    is_user_nxt    = ACCTYPE[0];
                    busy_nxt       = 1'b1;
                    cmd_sr_nxt     = {8'h03, flash_addr};
                    bytes_left_nxt = ACCTYPE[0] ? USER_BYTES : BOOT_BYTES;
                    if (PAD_EN && ACCTYPE[0]) begin
                        state_nxt    = S_PADPRE;
                        addr_nxt     = PAD_FIRST;
                        wr_phase_nxt = 2'd0;
                        wr_cnt_nxt   = '0;
                        wrdata_nxt   = 1'b0;
                    end else begin
                        state_nxt   = S_CMD;
                        addr_nxt    = ACCTYPE[0] ? USER_FIRST : BOOT_FIRST;
                        ncs_nxt     = 1'b0;
                        sclk_nxt    = 1'b0;
                        mosi_nxt    = 1'b0;
                        div_cnt_nxt = '0;
                        bit_cnt_nxt = '0;
                    end
                end
            end
            S_PADPRE: begin
                if (wr_end) begin
                    addr_nxt = addr + 15'd1;
                    if (wr_cnt == PRE_LAST) begin
                        state_nxt   = S_CMD;
                        ncs_nxt     = 1'b0;
                        sclk_nxt    = 1'b0;
                        mosi_nxt    = cmd_sr[31];
                        div_cnt_nxt = '0;
                        bit_cnt_nxt = '0;
                    end else begin
                        wr_cnt_nxt   = wr_cnt + 8'd1;
                        wr_phase_nxt = 2'd0;
                    end
                end
            end
            S_CMD: begin
                if (div_end) begin
                    div_cnt_nxt = '0;
                    sclk_nxt    = ~sclk;
                    // MOSI advances on the falling edge so it is stable at the next rise
                    if (sclk) begin
                        if (bit_cnt == 5'd31) begin
                            state_nxt   = S_RDBYTE;
                            bit_cnt_nxt = '0;
                            mosi_nxt    = 1'b0;
                        end else begin
                            cmd_sr_nxt  = {cmd_sr[30:0], 1'b0};
                            mosi_nxt    = cmd_sr[30];
                            bit_cnt_nxt = bit_cnt + 5'd1;
                        end
                    end
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end
            S_RDBYTE: begin
                if (div_end) begin
                    div_cnt_nxt = '0;
                    if (!sclk) begin
                        sclk_nxt  = 1'b1;
                        rx_sr_nxt = {rx_sr[6:0], MISO};
                    end else begin
                        sclk_nxt = 1'b0;
                        if (bit_cnt == 5'd7) begin
                            state_nxt    = S_WRBITS;
                            wr_phase_nxt = 2'd0;
                            wr_cnt_nxt   = '0;
                            wrdata_nxt   = rx_sr[7];
                        end else begin
                            bit_cnt_nxt = bit_cnt + 5'd1;
                        end
                    end
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end
            S_WRBITS: begin
                if (wr_end) begin
                    if (wr_cnt == 8'd7) begin
                        bytes_left_nxt = bytes_left - 9'd1;
                        if (bytes_left == 9'd1) begin
                            if (PAD_EN && is_user) begin
                                state_nxt    = S_PADPOST;
                                addr_nxt     = addr + 15'd1;
                                wr_cnt_nxt   = '0;
                                wr_phase_nxt = 2'd0;
                                wrdata_nxt   = 1'b0;
                            end else begin
                                state_nxt = S_DONE;
                            end
                        end else begin
                            state_nxt   = S_RDBYTE;
                            addr_nxt    = addr + 15'd1;
                            div_cnt_nxt = '0;
                            bit_cnt_nxt = '0;
                            sclk_nxt    = 1'b0;
                        end
                    end else begin
                        addr_nxt     = addr + 15'd1;
                        rx_sr_nxt    = {rx_sr[6:0], 1'b0};
                        wrdata_nxt   = rx_sr[6];
                        wr_cnt_nxt   = wr_cnt + 8'd1;
                        wr_phase_nxt = 2'd0;
                    end
                end
            end
            S_PADPOST: begin
                if (wr_end) begin
                    if (wr_cnt == POST_LAST) begin
                        state_nxt = S_DONE;
                    end else begin
                        addr_nxt     = addr + 15'd1;
                        wr_cnt_nxt   = wr_cnt + 8'd1;
                        wr_phase_nxt = 2'd0;
                    end
                end
            end
            S_DONE: begin
                ncs_nxt   = 1'b1;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign LOADBUSY  = busy;
    assign LOADDONE  = done;
    assign nCS       = ncs;
    assign SCLK      = sclk;
    assign MOSI      = mosi;
    assign BUFWRADDR = addr;
    assign BUFWRCLK  = wrclk;
    assign BUFWRDATA = wrdata;

endmodule

// File: doc/bubble_buffer_loader.md
Name: bubble_buffer_loader

Overview:
- Sits directly upstream of the bubble buffer. It feeds the BUFWRADDR/BUFWRCLK/BUFWRDATA write port of the D0/D1 bit buffers.
- On a load request it reads the bootloader or one user page from SPI flash (command 0x03). It then serializes the bytes into 2-bit-mode buffer write addresses.
- The load must complete before the bubble output timing starts reading the buffer.

Parameters:
- SPI_DIV, 2, MCLK cycles per SCLK half-period (min 1).
- BOOT_BASE, 24'h000000, flash byte address of the 480-byte bootloader.
- PAGE_BASE, 24'h001000, flash byte address of page 0; each page is 128 bytes.

Ports:
- MCLK  input  1  48MHz clock.
- nRESET  input  1  asynchronous active-low reset.
- LOADREQ  input  1  one-cycle start strobe, sampled in IDLE only.
- ACCTYPE  input  3  access type: 3'b110 = BOOT, 3'b111 = USER.
- ABSPOS  input  12  page number for USER loads.
- LOADBUSY  output  1  high from request acceptance until the DONE state.
- LOADDONE  output  1  one-cycle pulse when the final buffer write completes.
- nCS  output  1  SPI chip select, active low.
- SCLK  output  1  SPI clock, mode 0, idle low.
- MOSI  output  1  SPI data out.
- MISO  input  1  SPI data in, sampled on SCLK rising edge.
- BUFWRADDR  output  15  buffer write address; bit0 = channel (0 = D0, 1 = D1), [13:1] = bit position.
- BUFWRCLK  output  1  write strobe; buffer captures on its rising edge.
- BUFWRDATA  output  1  write data.

Behaviour:
- Reset values: LOADBUSY=0, LOADDONE=0, nCS=1, SCLK=0, MOSI=0, BUFWRADDR=0, BUFWRCLK=0, BUFWRDATA=0, state=IDLE.
- Reset asserted mid-load:
  - All outputs return to reset values immediately.
  - The load is aborted and no LOADDONE is issued.
- Request decode in IDLE, when LOADREQ=1:
  - BOOT: flash address = BOOT_BASE, byte count = 480, first write address = 4106 (position 2053, D0).
  - USER: flash address = PAGE_BASE + {ABSPOS,7'b0}, 24-bit wrap, byte count = 128, first write address = 14342 (position 7171, D0).
  - Any other ACCTYPE: request ignored, LOADBUSY stays 0.
  - ACCTYPE and ABSPOS are latched on acceptance.
- LOADREQ while busy: ignored.
- State machine:
  - IDLE -> CMD on an accepted request.
  - CMD -> RDBYTE -> WRBITS -> RDBYTE (repeated) ... -> DONE -> IDLE.
- CMD:
  - nCS falls.
  - 32 bits are shifted MSB first: 8'h03 followed by the 24-bit address.
  - MOSI changes while SCLK is low. Each SCLK phase lasts SPI_DIV MCLK.
- RDBYTE:
  - 8 SCLK cycles; MISO is shifted in MSB first.
  - nCS stays low for the whole transfer and is not re-asserted between bytes.
  - SCLK is held low while in WRBITS.
- WRBITS: 8 writes, byte MSB first, each write 3 MCLK:
  - Cycle 0: BUFWRADDR and BUFWRDATA set.
  - Cycle 1: BUFWRCLK=1.
  - Cycle 2: BUFWRCLK=0, then the address increments by 1.
- BUFWRADDR increments 15-bit with no wrap in normal use.
  - Final BOOT address = 7945; final USER address = 15365.
- DONE (1 cycle):
  - nCS=1, LOADDONE=1, LOADBUSY=0.
  - BUFWRADDR holds its last value.
- Latency, SPI_DIV=2:
  - CMD = 128 MCLK.
  - Each byte = 32 MCLK read + 24 MCLK write.
  - USER total = 128 + 128*56 + 2 = 7298 MCLK.

Optional Feature:
- Macro: LOADER_PAD_EN.
- Defined, USER loads add zero padding:
  - Before the data: 6 zero writes to addresses 14336-14341 (positions 7168-7170).
  - After the data: 138 zero writes to addresses 15366-15503 (positions 7683-7751).
  - Same 3-MCLK write timing as WRBITS.
  - LOADDONE follows the last pad write.
  - BOOT loads are unchanged.
- Undefined: no pad writes; the first USER write is at 14342.

Test Plan:
- Reset: hold nRESET=0 -> nCS=1, SCLK=0, LOADBUSY=0, BUFWRCLK=0.
- USER load, ABSPOS=12'h005, SPI_DIV=2, flash model returns bytes 0xA5, 0x3C, ...
  - Required: MOSI sends 0x03 then 0x001280.
  - Required: first eight writes are addr 14342..14349 with data 1,0,1,0,0,1,0,1.
  - Required: final write at 15365; LOADDONE exactly 7298 cycles after LOADREQ.
- BOOT load -> 480 bytes read from 0x000000; writes span 4106..7945 (3840 strobes); single LOADDONE pulse.
- LOADREQ with ACCTYPE=3'b000, and a second LOADREQ mid-load -> both ignored; LOADBUSY and the ongoing transfer are unaffected.
- nRESET asserted during the 50th byte -> outputs return to reset values at once, nCS=1, no LOADDONE; a new USER load then completes normally.
- LOADER_PAD_EN defined, USER load -> 6 zero writes at 14336..14341, then data, then 138 zero writes ending at 15503; then LOADDONE.
